// File: rtl/key_go_conditioner.sv
// rtl/key_go_conditioner.sv - push-button to go-level conditioner with operand tracking and busy lockout
// Define KEYCOND_DEBOUNCE_EN to enable the debounce counter; without it the synchronizer output is taken directly.
module key_go_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int COMPUTE_CYCLES  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       go,
    output logic       go_pulse,
    output logic [1:0] operand_idx,
    output logic       busy,
    output logic       done_pulse
);

    localparam int BCNT_W = $clog2(COMPUTE_CYCLES + 1);

    typedef enum logic {
        ST_ENTER = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q;
    logic                stable_q, stable_d;
    logic                stable_dly_q;
    logic                ignore_q, ignore_d;
    logic [1:0]          idx_q, idx_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                rise, fall, done;

`ifdef KEYCOND_DEBOUNCE_EN
    logic                sync2_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (CNT_W > 0) ^ (DEBOUNCE_CYCLES > 0);

    // stable_q doubles as the second synchronizer stage, giving a two-edge press latency.
    always_comb begin
        stable_d = sync1_q;
    end
`endif

    assign rise = stable_q & ~stable_dly_q;
    assign fall = ~stable_q & stable_dly_q;

    always_comb begin
        ignore_d = ignore_q;
        if (rise && (state_q == ST_BUSY)) begin
            ignore_d = 1'b1;
        end else if (fall) begin
            ignore_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        done    = 1'b0;
        case (state_q)
            ST_ENTER: begin
                if (fall && !ignore_q) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        state_d = ST_BUSY;
                        bcnt_d  = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bcnt_q == BCNT_W'(COMPUTE_CYCLES - 1)) begin
                    done    = 1'b1;
                    state_d = ST_ENTER;
                    idx_d   = 2'd0;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTER;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            ignore_q     <= 1'b0;
            state_q      <= ST_ENTER;
            idx_q        <= 2'd0;
            bcnt_q       <= '0;
        end else begin
            sync1_q      <= ~key_n;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            ignore_q     <= ignore_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
        end
    end

    // Outputs are decoded from flops only, so go lines up with the debounced level edge.
    assign busy        = (state_q == ST_BUSY);
    assign go          = stable_q & ~ignore_q & ~busy;
    assign go_pulse    = rise & ~ignore_d & (state_q == ST_ENTER);
    assign done_pulse  = done;
    assign operand_idx = idx_q;

endmodule

// File: tb/tb_key_go_conditioner.sv
// tb/tb_key_go_conditioner.sv - scoreboard bench for key_go_conditioner
module tb_key_go_conditioner;

    localparam int DEB  = 4;
    localparam int COMP = 5;
`ifdef KEYCOND_DEBOUNCE_EN
    localparam int L = DEB + 2;
`else
    localparam int L = 2;
`endif

    localparam int EV_PULSE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_BUSY  = 2;
    localparam int EV_IDX   = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       go, go_pulse, busy, done_pulse;
    logic [1:0] operand_idx;

    ev_t        evq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_idx = 0;
    bit         started = 1'b0;
    logic       busy_prev;
    logic [1:0] idx_prev;

    key_go_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .COMPUTE_CYCLES (COMP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .go         (go),
        .go_pulse   (go_pulse),
        .operand_idx(operand_idx),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        evq.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d", kind, val, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                errors++;
                $display("FAIL event actual kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            if (go_pulse) begin
                check_ev(EV_PULSE, 0);
                chk("go_at_pulse", int'(go), 1);
            end
            if (done_pulse) begin
                check_ev(EV_DONE, 0);
                chk("busy_at_done", int'(busy), 1);
            end
            if (busy && !busy_prev) check_ev(EV_BUSY, 0);
            if (operand_idx != idx_prev) check_ev(EV_IDX, int'(operand_idx));
            busy_prev = busy;
            idx_prev  = operand_idx;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int low, input int high, output int tr);
        int t0;
        key_n = 1'b0;
        t0    = cyc;
        push(EV_PULSE, t0 + L, 0);
        tick(low);
        key_n = 1'b1;
        tr    = cyc;
        if (exp_idx < 3) begin
            push(EV_IDX, tr + L + 1, exp_idx + 1);
            exp_idx++;
        end else begin
            push(EV_BUSY, tr + L + 1, 0);
            push(EV_DONE, tr + L + COMP, 0);
            push(EV_IDX, tr + L + COMP + 1, 0);
            exp_idx = 0;
        end
        tick(high);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        if (exp_idx != 0) push(EV_IDX, cyc, 0);
        exp_idx = 0;
        #1;
        chk({tag, "_idx"}, int'(operand_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_go"}, int'(go), 0);
        tick(2);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        int t0, tr, tp, n, gobad;
        bit ignored;
        reset = 1'b1;
        key_n = 1'b1;
        tick(3);
        chk("rst_go", int'(go), 0);
        chk("rst_go_pulse", int'(go_pulse), 0);
        chk("rst_idx", int'(operand_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_pulse), 0);
        reset     = 1'b0;
        busy_prev = busy;
        idx_prev  = operand_idx;
        started   = 1'b1;
        tick(3);

        // Reset lands while the press is still being qualified.
        key_n = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        chk("t1_go", int'(go), 0);
        chk("t1_go_pulse", int'(go_pulse), 0);
        chk("t1_busy", int'(busy), 0);
        tick(3);
        reset = 1'b0;
        n = cyc;
        push(EV_PULSE, n + L, 0);
        tick(10);
        key_n = 1'b1;
        tr = cyc;
        push(EV_IDX, tr + L + 1, 1);
        exp_idx = 1;
        tick(10);

        // Bounce: low 3, high 1, low 10.
        key_n = 1'b0;
        t0 = cyc;
`ifdef KEYCOND_DEBOUNCE_EN
        tick(3);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        push(EV_PULSE, t0 + 4 + L, 0);
`else
        push(EV_PULSE, t0 + L, 0);
        tick(3);
        key_n = 1'b1;
        push(EV_PULSE, t0 + 4 + L, 0);
        push(EV_IDX, t0 + 3 + L + 1, exp_idx + 1);
        exp_idx++;
        tick(1);
        key_n = 1'b0;
`endif
        tick(10);
        key_n = 1'b1;
        tr = cyc;
        push(EV_IDX, tr + L + 1, exp_idx + 1);
        exp_idx++;
        tick(10);
        chk("t2_idx", int'(operand_idx), exp_idx);

        // Reset mid-entry, then one press.
        do_reset("t5");
        press(8, 8, tr);
        chk("t5_idx", int'(operand_idx), 1);

        // Four presses into a compute burst.
        do_reset("t3pre");
        press(8, 8, tr);
        press(8, 8, tr);
        press(8, 8, tr);
        chk("t3_idx3", int'(operand_idx), 3);
        press(8, 0, tr);

        // Press starting on the second busy cycle.
        tick(L + 2);
        key_n   = 1'b0;
        tp      = cyc;
        ignored = (tp <= tr + COMP);
        if (!ignored) push(EV_PULSE, tp + L, 0);
        gobad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (go) gobad++;
        end
        key_n = 1'b1;
        if (!ignored) begin
            push(EV_IDX, cyc + L + 1, 1);
            exp_idx = 1;
        end
        tick(12);
        chk("t4_idx", int'(operand_idx), exp_idx);
        if (ignored) chk("t4_go_held_low", gobad, 0);

`ifndef KEYCOND_DEBOUNCE_EN
        // Single-cycle press with no debounce.
        key_n = 1'b0;
        t0    = cyc;
        push(EV_PULSE, t0 + 2, 0);
        tick(1);
        key_n = 1'b1;
        push(EV_IDX, t0 + 4, exp_idx + 1);
        exp_idx++;
        tick(1);
        chk("t6_go_high", int'(go), 1);
        tick(1);
        chk("t6_go_low", int'(go), 0);
        tick(8);
        chk("t6_idx", int'(operand_idx), exp_idx);
`endif

        tick(20);
        chk("queue_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
